spi_reg_ctrl: RTL and testbench

SPI-slave register controller that configures the PWM output datapath of the onboarding design. It receives fixed 16-bit SPI frames on three user input pins, decodes write transactions and updates five 8-bit configuration registers: output enables, PWM enables and PWM duty cycle. The registers feed the PWM peripheral directly. The block sits between `ui_in` and the PWM peripheral inside the top-level `tt_um_` wrapper.

---
 rtl/spi_reg_ctrl.sv | 173 +++++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl -- SPI-slave (mode 0) register controller for the PWM datapath.
//
// Receives 16-bit frames MSB first: bit 15 = R/W (1 = write), bits 14:8 =
// address, bits 7:0 = data. A complete 16-bit write to a valid address
// updates one of five 8-bit configuration registers and pulses wr_strobe.
//
// Optional build macro: SPI_READBACK_EN
//   defined   -> read frames shift the addressed register out on cipo
//   undefined -> cipo tied low, read frames are discarded
//
// Ports:
//   clk, rst_n        system clock, synchronous active-low reset
//   sclk, copi, ncs   asynchronous SPI pins (synchronized internally)
//   cipo              SPI data out (readback build only, else 0)
//   en_reg_out_7_0    reg 0x00     en_reg_out_15_8  reg 0x01
//   en_reg_pwm_7_0    reg 0x02     en_reg_pwm_15_8  reg 0x03
//   pwm_duty_cycle    reg 0x04
//   wr_strobe         one-cycle pulse per committed write
module spi_reg_ctrl #(
  parameter int MAX_ADDR    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_strobe
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACTIVE  = 2'd1;
  localparam logic [1:0] S_OVERRUN = 2'd2;

  localparam logic [6:0] MAX_A = 7'(MAX_ADDR);

  logic [SYNC_STAGES-1:0] sclk_sync, copi_sync, ncs_sync;
  logic                   sclk_hist, copi_hist, ncs_hist;
  logic                   sclk_rise, ncs_rise, ncs_fall;
  logic [1:0]             state;
  logic [4:0]             cnt;
  logic [15:0]            sr;

  assign sclk_rise =  sclk_sync[SYNC_STAGES-1] & ~sclk_hist;
  assign ncs_rise  =  ncs_sync[SYNC_STAGES-1]  & ~ncs_hist;
  assign ncs_fall  = ~ncs_sync[SYNC_STAGES-1]  &  ncs_hist;

  // Sync/history flops reset to 0, including ncs: if the pin is already low
  // when reset releases, no falling edge is ever seen, so a frame in flight
  // is ignored until ncs goes high and falls again. A high pin just produces
  // a rising edge in IDLE, which is harmless.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync       <= '0;
      copi_sync       <= '0;
      ncs_sync        <= '0;
      sclk_hist       <= 1'b0;
      copi_hist       <= 1'b0;
      ncs_hist        <= 1'b0;
      state           <= S_IDLE;
      cnt             <= '0;
      sr              <= '0;
      wr_strobe       <= 1'b0;
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
      pwm_duty_cycle  <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      copi_sync <= {copi_sync[SYNC_STAGES-2:0], copi};
      ncs_sync  <= {ncs_sync[SYNC_STAGES-2:0], ncs};
      sclk_hist <= sclk_sync[SYNC_STAGES-1];
      copi_hist <= copi_sync[SYNC_STAGES-1];
      ncs_hist  <= ncs_sync[SYNC_STAGES-1];
      wr_strobe <= 1'b0;

      case (state)
        S_IDLE: begin
          if (ncs_fall) begin
            state <= S_ACTIVE;
            cnt   <= '0;
            sr    <= '0;
          end
        end
        S_ACTIVE: begin
          // ncs rise has priority over a coincident sclk rise
          if (ncs_rise) begin
            state <= S_IDLE;
            if (cnt == 5'd16 && sr[15] && sr[14:8] <= MAX_A) begin
              // addresses in range but without a register still strobe
              wr_strobe <= 1'b1;
              case (sr[14:8])
                7'd0:    en_reg_out_7_0  <= sr[7:0];
                7'd1:    en_reg_out_15_8 <= sr[7:0];
                7'd2:    en_reg_pwm_7_0  <= sr[7:0];
                7'd3:    en_reg_pwm_15_8 <= sr[7:0];
                7'd4:    pwm_duty_cycle  <= sr[7:0];
                default: ;
              endcase
            end
          end else if (sclk_rise) begin
            if (cnt == 5'd16) begin
              state <= S_OVERRUN;
            end else begin
              // copi_hist is the data value from the cycle sclk was still
              // low, i.e. the bit settled before the edge
              sr  <= {sr[14:0], copi_hist};
              cnt <= cnt + 5'd1;
            end
          end
        end
        S_OVERRUN: begin
          if (ncs_rise) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SPI_READBACK_EN
  logic       sclk_fall;
  logic [7:0] rd_val, rd_sr;
  logic       rd_act;

  assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_hist;

  // after 8 rises sr[7:0] holds R/W + address of the current frame
  always_comb begin
    rd_val = '0;
    case (sr[6:0])
      7'd0:    rd_val = en_reg_out_7_0;
      7'd1:    rd_val = en_reg_out_15_8;
      7'd2:    rd_val = en_reg_pwm_7_0;
      7'd3:    rd_val = en_reg_pwm_15_8;
      7'd4:    rd_val = pwm_duty_cycle;
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cipo   <= 1'b0;
      rd_sr  <= '0;
      rd_act <= 1'b0;
    end else if (state != S_ACTIVE || ncs_rise) begin
      cipo   <= 1'b0;
      rd_act <= 1'b0;
    end else if (sclk_fall) begin
      if (cnt == 5'd8 && !sr[7] && sr[6:0] <= MAX_A) begin
        cipo   <= rd_val[7];
        rd_sr  <= {rd_val[6:0], 1'b0};
        rd_act <= 1'b1;
      end else if (rd_act && cnt < 5'd16) begin
        cipo  <= rd_sr[7];
        rd_sr <= {rd_sr[6:0], 1'b0};
      end else begin
        cipo   <= 1'b0;
        rd_act <= 1'b0;
      end
    end
  end
`else
  assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: frames driven at clk/10 SPI rate, a
// register model predicts every commit, and expected results travel through
// a queue from the end of each frame to the cycle the DUT must update.
module tb_spi_reg_ctrl;

`ifdef SPI_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  typedef struct packed {
    logic        stb;
    logic [39:0] regs;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic       ncs = 1'b1;
  logic       cipo;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8, pwm_duty_cycle;
  logic       wr_strobe;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_regs [5];
  exp_t       q [$];

  spi_reg_ctrl dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
    .cipo(cipo),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "timeout");
  end

  function automatic logic [39:0] dut_regs();
    return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0,
            en_reg_out_15_8, en_reg_out_7_0};
  endfunction

  function automatic logic [39:0] pack();
    return {exp_regs[4], exp_regs[3], exp_regs[2], exp_regs[1], exp_regs[0]};
  endfunction

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic begin_frame();
    ncs = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // cipo is sampled at the end of the low phase, reflecting the previous fall
  task automatic send_bit(input logic b, input logic expc, input string tag);
    copi = b;
    repeat (4) @(negedge clk);
    chk(tag, {39'b0, cipo}, {39'b0, expc});
    @(negedge clk);
    sclk = 1'b1;
    repeat (5) @(negedge clk);
    sclk = 1'b0;
  endtask

  task automatic end_frame(input bit commit, input int a, input logic [7:0] dat,
                           input string tag);
    exp_t        e;
    logic [39:0] pre;
    repeat (5) @(negedge clk);
    ncs = 1'b1;
    pre = pack();
    if (commit) exp_regs[a] = dat;
    e.stb  = commit;
    e.regs = pack();
    q.push_back(e);
    @(posedge clk); #1;
    chk({tag, " stb_c1"}, {39'b0, wr_strobe}, 40'd0);
    @(posedge clk); #1;
    chk({tag, " regs_c2"}, dut_regs(), pre);
    chk({tag, " stb_c2"}, {39'b0, wr_strobe}, 40'd0);
    @(posedge clk); #1;
    e = q.pop_front();
    chk({tag, " regs_c3"}, dut_regs(), e.regs);
    chk({tag, " stb_c3"}, {39'b0, wr_strobe}, {39'b0, e.stb});
    @(posedge clk); #1;
    chk({tag, " stb_c4"}, {39'b0, wr_strobe}, 40'd0);
    repeat (5) @(negedge clk);
  endtask

  task automatic frame(input logic [15:0] d, input int nbits, input string tag);
    int   a;
    bit   commit;
    logic b, ec;
    a = int'(d[14:8]);
    begin_frame();
    for (int i = 0; i < nbits; i++) begin
      b  = (i < 16) ? d[15-i] : 1'b0;
      ec = 1'b0;
      if (RB && !d[15] && a <= 4 && i >= 8 && i < 16) ec = exp_regs[a][15-i];
      send_bit(b, ec, $sformatf("%s cipo_b%0d", tag, i));
    end
    commit = (nbits == 16) && d[15] && (a <= 4);
    end_frame(commit, a, d[7:0], tag);
  endtask

  initial begin
    logic [15:0] d;
    for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;

    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset regs", dut_regs(), 40'd0);
    chk("reset stb", {39'b0, wr_strobe}, 40'd0);
    chk("reset cipo", {39'b0, cipo}, 40'd0);
    repeat (4) @(negedge clk);

    frame(16'h80FF, 16, "wr0_ff");
    frame(16'h8455, 16, "wr4_55");
    frame(16'h84AA, 16, "wr4_aa");
    frame(16'h8533, 16, "wr5_oob");
    frame(16'h8312, 15, "short15");
    frame(16'h8334, 17, "over17");
    frame(16'h8301, 16, "wr3_01");

    // reset in the middle of a write, released with ncs still low
    d = 16'h8277;
    begin_frame();
    for (int i = 0; i < 8; i++) send_bit(d[15-i], 1'b0, $sformatf("midrst cipo_b%0d", i));
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) exp_regs[i] = 8'h00;
    chk("midrst regs", dut_regs(), 40'd0);
    chk("midrst stb", {39'b0, wr_strobe}, 40'd0);
    rst_n = 1'b1;
    for (int i = 8; i < 16; i++) send_bit(d[15-i], 1'b0, $sformatf("midrst cipo_b%0d", i));
    end_frame(1'b0, 2, 8'h77, "midrst");
    frame(16'h8277, 16, "wr2_77");

    frame(16'h80FF, 16, "wr0_ff2");
    frame(16'h0012, 16, "rd0");
    frame(16'h81C3, 16, "wr1_c3");
    frame(16'h0100, 16, "rd1");
    frame(16'h0700, 16, "rd7_oob");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
